// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with the acknowledge and a 40-bit frame.
// Optional DHT11_RESP_CHKERR_EN adds i_corrupt_chk to invert checksum bit 0 for fault injection.
module dht11_responder #(
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned ACK_US        = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_humid_int,
  input  logic [7:0] i_humid_dec,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_dec,
  input  logic       i_dat_in,
`ifdef DHT11_RESP_CHKERR_EN
  input  logic       i_corrupt_chk,
`endif
  output logic       o_dat_oe,
  output logic       o_busy,
  output logic [7:0] o_frame_count
);

  typedef enum logic [2:0] {
    IDLE, START_LOW, WAIT_REL, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  localparam logic [15:0] START_MIN  = 16'(START_MIN_US);
  localparam logic [15:0] RESP_LAST  = 16'(RESP_DELAY_US - 1);
  localparam logic [15:0] ACK_LAST   = 16'(ACK_US - 1);
  localparam logic [15:0] LOW_LAST   = 16'(BIT_LOW_US - 1);
  localparam logic [15:0] BIT0_LAST  = 16'(BIT0_HIGH_US - 1);
  localparam logic [15:0] BIT1_LAST  = 16'(BIT1_HIGH_US - 1);

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_shadow;
  logic [39:0] r_shift;

  logic        w_line;
  logic [7:0]  w_sum;
  logic [7:0]  w_chk;
  logic [15:0] w_high_last;

  assign w_line = r_sync[1];
  assign w_sum  = r_shadow[31:24] + r_shadow[23:16] + r_shadow[15:8] + r_shadow[7:0];
`ifdef DHT11_RESP_CHKERR_EN
  assign w_chk  = w_sum ^ {7'd0, i_corrupt_chk};
`else
  assign w_chk  = w_sum;
`endif
  assign w_high_last = r_shift[39] ? BIT1_LAST : BIT0_LAST;

  // Synchronizers idle high like the pulled-up line; from ACK_LOW onward w_line is never consulted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_sync        <= 2'b11;
      r_cnt         <= 16'd0;
      r_bit_cnt     <= 6'd0;
      r_shadow      <= 32'd0;
      r_shift       <= 40'd0;
      o_dat_oe      <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= 8'd0;
    end else begin
      r_sync <= {r_sync[0], i_dat_in};
      if (i_load) r_shadow <= {i_humid_int, i_humid_dec, i_temp_int, i_temp_dec};
      case (r_state)
        IDLE: begin
          o_dat_oe <= 1'b0;
          if (!w_line) begin
            r_state <= START_LOW;
            r_cnt   <= 16'd0;
          end
        end
        START_LOW: begin
          if (!w_line) begin
            if (r_cnt < START_MIN) r_cnt <= r_cnt + 16'd1;
          end else if (r_cnt >= START_MIN) begin
            r_state <= WAIT_REL;
            r_cnt   <= 16'd0;
            o_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_REL: begin
          if (!w_line) begin
            r_state <= START_LOW;
            r_cnt   <= 16'd0;
            o_busy  <= 1'b0;
          end else if (r_cnt == RESP_LAST) begin
            r_state  <= ACK_LOW;
            r_cnt    <= 16'd0;
            o_dat_oe <= 1'b1;
            r_shift  <= {r_shadow, w_chk};
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ACK_LOW: begin
          if (r_cnt == ACK_LAST) begin
            r_state  <= ACK_HIGH;
            r_cnt    <= 16'd0;
            o_dat_oe <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ACK_HIGH: begin
          if (r_cnt == ACK_LAST) begin
            r_state   <= BIT_LOW;
            r_cnt     <= 16'd0;
            r_bit_cnt <= 6'd0;
            o_dat_oe  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        BIT_LOW: begin
          if (r_cnt == LOW_LAST) begin
            r_state  <= BIT_HIGH;
            r_cnt    <= 16'd0;
            o_dat_oe <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        BIT_HIGH: begin
          if (r_cnt == w_high_last) begin
            r_shift  <= {r_shift[38:0], 1'b0};
            r_cnt    <= 16'd0;
            o_dat_oe <= 1'b1;
            if (r_bit_cnt == 6'd39) begin
              r_state <= END_LOW;
            end else begin
              r_state   <= BIT_LOW;
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        END_LOW: begin
          if (r_cnt == LOW_LAST) begin
            r_state       <= IDLE;
            r_cnt         <= 16'd0;
            o_dat_oe      <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_count <= o_frame_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          o_dat_oe <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Scoreboard bench for dht11_responder: stimulus pushes expected frames, a monitor decodes dat_oe pulses.
// Build with DHT11_RESP_CHKERR_EN defined to also exercise the corrupted-checksum frame.
`timescale 1ns/1ps
module tb_dht11_responder;

  // Start threshold scaled down from 18 ms to keep runtime short; all pulse timings stay nominal.
  localparam int START_US   = 1800;
  localparam int HOST_LOW   = START_US + 20;
  localparam int GLITCH_LOW = 1000;
  localparam int RUN_LIMIT  = 200;

  typedef struct {
    logic [39:0] frame;
    logic [7:0]  count;
    bit          abort;
    int          relCyc;
  } expItem_t;

  logic clk = 1'b0;
  logic rstN;
  logic load;
  logic [7:0] humidInt, humidDec, tempInt, tempDec;
  logic hostLow;
  logic datOe;
  logic busy;
  logic [7:0] frameCount;
`ifdef DHT11_RESP_CHKERR_EN
  logic corruptChk;
`endif
  wire datLine = !(hostLow || datOe);

  int cyc = 0;
  int nChecks = 0;
  int nPass = 0;
  int monBit = -1;
  bit monHigh = 1'b0;
  bit monActive = 1'b0;
  expItem_t expQ[$];

  dht11_responder #(.START_MIN_US(START_US)) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_load(load),
    .i_humid_int(humidInt),
    .i_humid_dec(humidDec),
    .i_temp_int(tempInt),
    .i_temp_dec(tempDec),
    .i_dat_in(datLine),
`ifdef DHT11_RESP_CHKERR_EN
    .i_corrupt_chk(corruptChk),
`endif
    .o_dat_oe(datOe),
    .o_busy(busy),
    .o_frame_count(frameCount)
  );

  always #500 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Counts consecutive negedge samples sharing the current dat_oe level; stops early on reset.
  task automatic measureRun(output int len);
    logic lvl;
    lvl = datOe;
    len = 0;
    do begin
      len++;
      @(negedge clk);
    end while (datOe == lvl && rstN && len < RUN_LIMIT);
  endtask

  task automatic loadPayload(input logic [7:0] hi, input logic [7:0] hd,
                             input logic [7:0] ti, input logic [7:0] td);
    @(negedge clk);
    humidInt = hi; humidDec = hd; tempInt = ti; tempDec = td;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Host start pulse; a qualifying pulse queues the frame expected in response.
  task automatic applyStimulus(input int lowUs, input bit qualify, input logic [39:0] frame,
                               input logic [7:0] count, input bit abort);
    expItem_t item;
    @(negedge clk);
    hostLow = 1'b1;
    repeat (lowUs) @(negedge clk);
    hostLow = 1'b0;
    if (qualify) begin
      item.frame  = frame;
      item.count  = count;
      item.abort  = abort;
      item.relCyc = cyc;
      expQ.push_back(item);
    end
    repeat (4) @(negedge clk);
    checkOutput("busyAfterStart", 40'(busy), 40'(qualify));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || monActive) && n < 12000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 12000) checkOutput("drainTimeout", 40'(n), 40'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic waitBit(input int bitIdx, input bit high);
    int n;
    n = 0;
    while (!(monBit == bitIdx && monHigh == high) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) checkOutput("waitBitTimeout", 40'(bitIdx), 40'(monBit));
  endtask

  // Monitor: decodes every responder frame from dat_oe and scores it against the queue head.
  initial begin : monitor
    expItem_t it;
    int riseCyc, ackLow, ackHigh, lowLen, highLen, endLen, lowErr, highErr;
    logic [39:0] got;
    bit alive;
    forever begin
      @(negedge clk);
      if (rstN && datOe) begin
        monActive = 1'b1;
        riseCyc = cyc;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedFrame", 40'd1, 40'd0);
          it.frame = 40'd0; it.count = 8'd0; it.abort = 1'b0; it.relCyc = 0;
        end else begin
          it = expQ.pop_front();
        end
        // relCyc is taken just before the first clock edge that samples the released pad.
        checkOutput("ackLatency", 40'(riseCyc - it.relCyc - 1), 40'd32);
        got = 40'd0; lowErr = 0; highErr = 0;
        ackHigh = 0; endLen = 0;
        measureRun(ackLow);
        alive = rstN;
        if (alive) begin
          measureRun(ackHigh);
          alive = rstN;
        end
        for (int b = 0; b < 40; b++) begin
          if (alive) begin
            monBit = b;
            monHigh = 1'b0;
            measureRun(lowLen);
            alive = rstN;
            if (alive) begin
              monHigh = 1'b1;
              measureRun(highLen);
              alive = rstN;
              if (alive) begin
                got = {got[38:0], (highLen > 48)};
                if (lowLen != 50) lowErr++;
                if (highLen != (it.frame[39-b] ? 70 : 26)) highErr++;
              end
            end
          end
        end
        monBit = -1;
        monHigh = 1'b0;
        if (alive) begin
          measureRun(endLen);
          alive = rstN;
        end
        if (alive) begin
          checkOutput("frameCompletes", 40'(it.abort), 40'd0);
          checkOutput("ackLowLen", 40'(ackLow), 40'd80);
          checkOutput("ackHighLen", 40'(ackHigh), 40'd80);
          checkOutput("endLowLen", 40'(endLen), 40'd50);
          checkOutput("bitLowErrors", 40'(lowErr), 40'd0);
          checkOutput("bitHighErrors", 40'(highErr), 40'd0);
          for (int k = 0; k < 5; k++)
            checkOutput($sformatf("byte%0d", k), 40'(got[39-8*k -: 8]), 40'(it.frame[39-8*k -: 8]));
          checkOutput("frameCount", 40'(frameCount), 40'(it.count));
          checkOutput("busyAfterEnd", 40'(busy), 40'd0);
        end else begin
          checkOutput("frameAborted", 40'(it.abort), 40'd1);
        end
        monActive = 1'b0;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    rstN = 1'b0; load = 1'b0; hostLow = 1'b0;
    humidInt = 8'd0; humidDec = 8'd0; tempInt = 8'd0; tempDec = 8'd0;
`ifdef DHT11_RESP_CHKERR_EN
    corruptChk = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("resetDatOe", 40'(datOe), 40'd0);
    checkOutput("resetBusy", 40'(busy), 40'd0);
    checkOutput("resetFrameCount", 40'(frameCount), 40'd0);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] basic frame 37 00 19 00");
    loadPayload(8'h37, 8'h00, 8'h19, 8'h00);
    applyStimulus(HOST_LOW, 1'b1, 40'h37_00_19_00_50, 8'd1, 1'b0);
    waitDrain();

    $display("[TB] short host pulse is ignored");
    begin
      bit sawOe, sawBusy;
      sawOe = 1'b0; sawBusy = 1'b0;
      applyStimulus(GLITCH_LOW, 1'b0, 40'd0, 8'd0, 1'b0);
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        sawOe |= datOe;
        sawBusy |= busy;
      end
      checkOutput("glitchDatOe", 40'(sawOe), 40'd0);
      checkOutput("glitchBusy", 40'(sawBusy), 40'd0);
      checkOutput("glitchFrameCount", 40'(frameCount), 40'd1);
    end

    $display("[TB] all-ones payload");
    loadPayload(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(HOST_LOW, 1'b1, 40'hFF_FF_FF_FF_FC, 8'd2, 1'b0);
    waitDrain();

    $display("[TB] load during bit 12 only affects the next frame");
    applyStimulus(HOST_LOW, 1'b1, 40'hFF_FF_FF_FF_FC, 8'd3, 1'b0);
    waitBit(12, 1'b0);
    loadPayload(8'h20, 8'h00, 8'h10, 8'h00);
    waitDrain();
    applyStimulus(HOST_LOW, 1'b1, 40'h20_00_10_00_30, 8'd4, 1'b0);
    waitDrain();

    $display("[TB] reset during the high phase of bit 20");
    applyStimulus(HOST_LOW, 1'b1, 40'h20_00_10_00_30, 8'd5, 1'b1);
    waitBit(20, 1'b1);
    @(negedge clk);
    #200 rstN = 1'b0;
    #1;
    checkOutput("asyncResetDatOe", 40'(datOe), 40'd0);
    checkOutput("asyncResetBusy", 40'(busy), 40'd0);
    checkOutput("asyncResetFrameCount", 40'(frameCount), 40'd0);
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    waitDrain();
    loadPayload(8'h12, 8'h34, 8'h56, 8'h78);
    applyStimulus(HOST_LOW, 1'b1, 40'h12_34_56_78_14, 8'd1, 1'b0);
    waitDrain();

`ifdef DHT11_RESP_CHKERR_EN
    $display("[TB] corrupted checksum");
    corruptChk = 1'b1;
    loadPayload(8'h37, 8'h00, 8'h19, 8'h00);
    applyStimulus(HOST_LOW, 1'b1, 40'h37_00_19_00_51, 8'd2, 1'b0);
    waitDrain();
    corruptChk = 1'b0;
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Cycle-accurate DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol that our driver initiates. It watches the shared open-drain data line for a host start pulse, then drives the acknowledge and a 40-bit humidity/temperature/checksum frame with DHT11 pulse timing. It runs on the 1 MHz divided clock, so one clock equals 1 µs. It sits on a spare IO pin, looped to the driver's line, for bench and on-board self-test without a physical sensor.

## Interface
- START_MIN_US, 18000, minimum host low time, in cycles, that qualifies as a start request; must be below 65536.
- RESP_DELAY_US, 30, high time after the host releases the line before the acknowledge begins.
- ACK_US, 80, duration of the acknowledge low phase and of the acknowledge high phase.
- BIT_LOW_US, 50, low preamble before each bit and the trailing end pulse.
- BIT0_HIGH_US / BIT1_HIGH_US, 26 / 70, high time encoding a 0 / 1.
- clk  input  1  1 MHz clock (divided clock domain).
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; captures the four data inputs into the shadow register.
- humid_int, humid_dec, temp_int, temp_dec  input  8 each  frame payload bytes.
- dat_in  input  1  sampled data line (pull-up high).
- dat_oe  output  1  1 = pull the line low; 0 = release (open-drain; top level ties pad to 0 when dat_oe).
- busy  output  1  high from start qualification until the end pulse completes.
- frame_count  output  8  frames fully transmitted; wraps 255→0.
- corrupt_chk  input  1  present only with DHT11_RESP_CHKERR_EN.

## Operation
- dat_in passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Shadow register: on load, the four bytes are captured. On entry to ACK_LOW, shadow is copied into a 40-bit transmit shift register with checksum = (humid_int+humid_dec+temp_int+temp_dec) mod 256. A load during a frame affects only the next frame.
- States:
  - IDLE: dat_oe=0. Synced low → START_LOW, counter cleared.
  - START_LOW: counter increments, saturating at START_MIN_US, while low. Line high with counter ≥ START_MIN_US → WAIT_REL; line high earlier → IDLE (glitch rejected, no response).
  - WAIT_REL: busy=1. Count RESP_DELAY_US cycles → ACK_LOW. A low seen here returns to START_LOW (host retry).
  - ACK_LOW: dat_oe=1 for ACK_US. Then ACK_HIGH: dat_oe=0 for ACK_US.
  - BIT_LOW: dat_oe=1 for BIT_LOW_US. Then BIT_HIGH: dat_oe=0 for BIT0_HIGH_US or BIT1_HIGH_US per the current MSB.
  - After BIT_HIGH, shift left; bit counter 0..39. After bit 39 → END_LOW.
  - END_LOW: dat_oe=1 for BIT_LOW_US. Then → IDLE, busy=0, frame_count+1.
- Transmission order: humid_int, humid_dec, temp_int, temp_dec, checksum; MSB first.
- From ACK_LOW through END_LOW, dat_in is ignored; the responder owns the line.

## Timing
- Reset values: dat_oe=0, busy=0, frame_count=0, shadow and shift registers 0, state IDLE. Asserting rst_n mid-frame releases the line immediately (asynchronous).
- Start qualification latency: 2 sync cycles after the pad edge.
- Each phase lasts exactly its parameter value in cycles: dat_oe holds its value for N consecutive clocks.
- Release edge to acknowledge start: RESP_DELAY_US + 2 cycles at the pad.
- Frame length, from ACK_LOW start to END_LOW end: 2·ACK_US + 40·BIT_LOW_US + Σ high times + BIT_LOW_US.
- frame_count and busy update on the same clock as END_LOW → IDLE.
- load and the ACK_LOW snapshot on the same cycle: the snapshot uses the pre-load shadow contents.

## Configuration
- DHT11_RESP_CHKERR_EN defined: adds the corrupt_chk port. When it is 1 at snapshot time, checksum bit 0 is inverted for that frame, for host fault injection.
- DHT11_RESP_CHKERR_EN undefined: port absent; the checksum is always correct.

## Test plan
- Load 0x37,0x00,0x19,0x00; host low 18 ms, then release → acknowledge at +32 µs, bytes 37 00 19 00 50, frame_count=1, busy low after END_LOW.
- Host low 10 ms, then release → dat_oe stays 0, busy stays 0, frame_count unchanged.
- Load 0xFF,0xFF,0xFF,0xFF → checksum 0xFC; bit-1 high pulses measure exactly 70 cycles and bit-0 high pulses 26 cycles.
- load of 0x20,0,0x10,0 during bit 12 of a frame → current frame unchanged; next frame carries 20 00 10 00 30.
- rst_n low during BIT_HIGH of bit 20 → dat_oe=0 asynchronously, busy=0, frame_count=0; a new 18 ms start yields a complete frame.
- With DHT11_RESP_CHKERR_EN and corrupt_chk=1, payload 0x37,0,0x19,0 → checksum byte 0x51; the driver flags a checksum error.
